// File: rtl/scalar_wb_arbiter.sv
// Round-robin arbiter sharing the scalar register-file write port
// between the ALU, load return and vector reduction writeback sources.
module scalar_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int REG_W   = 5,
    parameter int DATA_W  = 36,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*REG_W-1:0]  req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wb_hold,
    output logic                      wb_en,
    output logic [REG_W-1:0]          wb_reg,
    output logic [DATA_W-1:0]         wb_data,
    output logic [2:0]                wb_src,
    output logic [CNT_W-1:0]          conflict_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  gidx;
    logic              found;
    logic [3:0]        vcnt;
    logic [REG_W-1:0]  sel_reg;
    logic [DATA_W-1:0] sel_data;
    int unsigned       idx;

    always_comb begin
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        if (!rst && !wb_hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    gidx  = idx[PTR_W-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found) req_ready[gidx] = 1'b1;
    end

    always_comb begin
        vcnt = '0;
        for (int k = 0; k < NUM_REQ; k++) vcnt = vcnt + 4'(req_valid[k]);
    end

    assign sel_reg  = req_reg[int'(gidx)*REG_W +: REG_W];
    assign sel_data = req_data[int'(gidx)*DATA_W +: DATA_W];

    // r0 writes are consumed but never reach the register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            wb_en        <= 1'b0;
            wb_reg       <= '0;
            wb_data      <= '0;
            wb_src       <= '0;
            conflict_cnt <= '0;
        end else begin
            wb_en <= 1'b0;
            if (found) begin
                rr_ptr <= (gidx == LAST) ? '0 : gidx + PTR_W'(1);
                if (sel_reg != '0) begin
                    wb_en   <= 1'b1;
                    wb_reg  <= sel_reg;
                    wb_data <= sel_data;
                    wb_src  <= 3'(gidx);
                end
            end
            if (vcnt >= 4'd2 && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

`ifndef SYNTHESIS
    a_onehot: assert property (@(posedge clk) $onehot0(req_ready));

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_chk
        a_hold: assert property (@(posedge clk) disable iff (rst)
            (req_valid[i] && !req_ready[i]) |=>
            (req_valid[i]
             && $stable(req_reg[i*REG_W +: REG_W])
             && $stable(req_data[i*DATA_W +: DATA_W])));
    end
`endif

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Scoreboard bench for scalar_wb_arbiter: a requester model drives
// the handshake and expected writebacks are queued one cycle ahead.
module tb_scalar_wb_arbiter;

    localparam int N  = 3;
    localparam int RW = 5;
    localparam int DW = 36;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*RW-1:0] req_reg;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            wb_hold;
    logic            wb_en;
    logic [RW-1:0]   wb_reg;
    logic [DW-1:0]   wb_data;
    logic [2:0]      wb_src;
    logic [CW-1:0]   conflict_cnt;

    scalar_wb_arbiter #(.NUM_REQ(N), .REG_W(RW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
        .req_ready(req_ready), .wb_hold(wb_hold),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .wb_src(wb_src), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic [RW-1:0] r;
        logic [DW-1:0] d;
        logic [2:0]    s;
    } wb_t;

    wb_t sbq[$];
    int total = 0;
    int bad = 0;

    logic          pend[N];
    logic [RW-1:0] preg[N];
    logic [DW-1:0] pdata[N];
    int            m_ptr;
    int            m_cnt;
    logic [N-1:0]  obs_ready;

    function automatic logic [RW-1:0] rnd_reg();
        return RW'($urandom_range(31, 1));
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {4'($urandom), 32'($urandom)};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            req_reg[i*RW +: RW] = preg[i];
            req_data[i*DW +: DW] = pdata[i];
        end
    endtask

    task automatic model_reset();
        wb_t z;
        z = '{en: 1'b0, r: '0, d: '0, s: '0};
        sbq.delete();
        sbq.push_back(z);
        m_ptr = 0;
        m_cnt = 0;
    endtask

    task automatic cycle(input logic hold, input logic rearm);
        int g;
        int nv;
        int k2;
        logic [N-1:0] er;
        wb_t e;
        wb_t x;
        @(negedge clk);
        drive();
        wb_hold = hold;
        #1;
        g = -1;
        nv = 0;
        for (int i = 0; i < N; i++) if (pend[i]) nv++;
        if (!hold) begin
            for (int k = 0; k < N; k++) begin
                k2 = (m_ptr + k) % N;
                if (g < 0 && pend[k2]) g = k2;
            end
        end
        er = (g >= 0) ? N'(1 << g) : '0;
        obs_ready = req_ready;
        total++;
        if (req_ready !== er) begin
            bad++;
            $display("FAIL ready: got %b want %b", req_ready, er);
        end
        total++;
        if (conflict_cnt !== CW'(m_cnt)) begin
            bad++;
            $display("FAIL conflict: got %0d want %0d", conflict_cnt, m_cnt);
        end
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got nothing want entry");
        end else begin
            e = sbq.pop_front();
            total++;
            if (wb_en !== e.en) begin
                bad++;
                $display("FAIL wb_en: got %b want %b", wb_en, e.en);
            end
            if (e.en) begin
                total++;
                if (wb_reg !== e.r || wb_data !== e.d || wb_src !== e.s) begin
                    bad++;
                    $display("FAIL wb_out: got r%0d %h s%0d want r%0d %h s%0d",
                             wb_reg, wb_data, wb_src, e.r, e.d, e.s);
                end
            end
        end
        x = '{en: 1'b0, r: '0, d: '0, s: '0};
        if (g >= 0 && preg[g] != '0)
            x = '{en: 1'b1, r: preg[g], d: pdata[g], s: 3'(g)};
        sbq.push_back(x);
        @(posedge clk);
        if (nv >= 2 && m_cnt < 65535) m_cnt++;
        if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (rearm) begin
                preg[g] = rnd_reg();
                pdata[g] = rnd_data();
            end else begin
                pend[g] = 1'b0;
            end
        end
    endtask

    task automatic check_ready(input string nm, input logic [N-1:0] want);
        total++;
        if (obs_ready !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, obs_ready, want);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1;
            preg[i] = rnd_reg();
            pdata[i] = rnd_data();
        end
        rst = 1'b1;
        wb_hold = 1'b0;
        drive();
        #12;
        total++;
        if (req_ready !== '0) begin
            bad++;
            $display("FAIL rst_ready: got %b want 000", req_ready);
        end
        total++;
        if ({wb_en, wb_reg, wb_data, wb_src} !== '0) begin
            bad++;
            $display("FAIL rst_wb: got %b %h %h %h want zeros",
                     wb_en, wb_reg, wb_data, wb_src);
        end
        total++;
        if (conflict_cnt !== '0) begin
            bad++;
            $display("FAIL rst_cnt: got %0d want 0", conflict_cnt);
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] order [6];
        order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1;
            preg[i] = rnd_reg();
            pdata[i] = rnd_data();
        end
        for (int c = 0; c < 6; c++) begin
            cycle(1'b0, 1'b1);
            check_ready("rr_order", order[c]);
        end
        #1;
        total++;
        if (conflict_cnt !== CW'(6)) begin
            bad++;
            $display("FAIL rr_conflict: got %0d want 6", conflict_cnt);
        end
        for (int c = 0; c < N; c++) cycle(1'b0, 1'b0);
    endtask

    task automatic test_single();
        pend[0] = 1'b1;
        preg[0] = 5'd7;
        pdata[0] = 36'h0_1234_5678;
        cycle(1'b0, 1'b0);
        check_ready("single_ready", 3'b001);
        #1;
        total++;
        if (wb_en !== 1'b1 || wb_reg !== 5'd7
            || wb_data !== 36'h0_1234_5678 || wb_src !== 3'd0) begin
            bad++;
            $display("FAIL single_wb: got %b r%0d %h s%0d want 1 r7 012345678 s0",
                     wb_en, wb_reg, wb_data, wb_src);
        end
        cycle(1'b0, 1'b0);
        #1;
        total++;
        if (wb_en !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: got %b want 0", wb_en);
        end
    endtask

    task automatic test_wrap_skip();
        pend[1] = 1'b1;
        preg[1] = rnd_reg();
        pdata[1] = rnd_data();
        cycle(1'b0, 1'b0);
        check_ready("wrap_pre", 3'b010);
        pend[0] = 1'b1;
        preg[0] = rnd_reg();
        pdata[0] = rnd_data();
        pend[1] = 1'b1;
        preg[1] = rnd_reg();
        pdata[1] = rnd_data();
        cycle(1'b0, 1'b0);
        check_ready("wrap_first", 3'b001);
        cycle(1'b0, 1'b0);
        check_ready("wrap_second", 3'b010);
    endtask

    task automatic test_hold();
        pend[1] = 1'b1;
        preg[1] = 5'd19;
        pdata[1] = 36'hA_5A5A_0F0F;
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 1'b0);
            check_ready("hold_ready", 3'b000);
            #1;
            total++;
            if (wb_en !== 1'b0) begin
                bad++;
                $display("FAIL hold_wb_en: got %b want 0", wb_en);
            end
        end
        cycle(1'b0, 1'b0);
        check_ready("hold_release", 3'b010);
        #1;
        total++;
        if (wb_en !== 1'b1 || wb_reg !== 5'd19 || wb_data !== 36'hA_5A5A_0F0F) begin
            bad++;
            $display("FAIL hold_write: got %b r%0d %h want 1 r19 a5a5a0f0f",
                     wb_en, wb_reg, wb_data);
        end
    endtask

    task automatic test_r0_discard();
        pend[2] = 1'b1;
        preg[2] = 5'd0;
        pdata[2] = 36'hF_FFFF_FFFF;
        cycle(1'b0, 1'b0);
        check_ready("r0_ready", 3'b100);
        #1;
        total++;
        if (wb_en !== 1'b0) begin
            bad++;
            $display("FAIL r0_wb_en: got %b want 0", wb_en);
        end
        pend[1] = 1'b1;
        preg[1] = rnd_reg();
        pdata[1] = rnd_data();
        pend[2] = 1'b1;
        preg[2] = rnd_reg();
        pdata[2] = rnd_data();
        cycle(1'b0, 1'b0);
        check_ready("r0_ptr", 3'b010);
        cycle(1'b0, 1'b0);
        check_ready("r0_next", 3'b100);
    endtask

    task automatic test_reset_midstream();
        pend[1] = 1'b1;
        preg[1] = 5'd11;
        pdata[1] = rnd_data();
        cycle(1'b0, 1'b0);
        @(negedge clk);
        for (int i = 1; i < N; i++) begin
            pend[i] = 1'b1;
            preg[i] = rnd_reg();
            pdata[i] = rnd_data();
        end
        drive();
        wb_hold = 1'b0;
        total++;
        if (wb_en !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre: got %b want 1", wb_en);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (wb_en !== 1'b0 || wb_reg !== '0 || wb_data !== '0) begin
            bad++;
            $display("FAIL mid_async: got %b r%0d %h want 0 r0 0",
                     wb_en, wb_reg, wb_data);
        end
        @(posedge clk);
        #1;
        total++;
        if (req_ready !== '0) begin
            bad++;
            $display("FAIL mid_ready: got %b want 000", req_ready);
        end
        #1 rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b0);
        check_ready("mid_first", 3'b010);
        cycle(1'b0, 1'b0);
        check_ready("mid_second", 3'b100);
    endtask

    initial begin
        req_valid = '0;
        req_reg = '0;
        req_data = '0;
        wb_hold = 1'b0;
        rst = 1'b1;
        m_ptr = 0;
        m_cnt = 0;
        obs_ready = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            preg[i] = '0;
            pdata[i] = '0;
        end
        test_reset();
        test_round_robin();
        test_single();
        test_wrap_skip();
        test_hold();
        test_r0_discard();
        test_reset_midstream();
        cycle(1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/scalar_wb_arbiter.md
Name: scalar_wb_arbiter

Overview:
- Shares the single scalar register-file write port among NUM_REQ writeback sources: scalar ALU, scalar load return, and vector-to-scalar reduction.
- Arbitration is round-robin with a valid/ready handshake.
- The granted write is registered, so it reaches the register file one cycle after acceptance.
- Sits between the execute/memory stages and the scalar register file; its outputs are the processor's scalar write register/data observed by the trace-driven bench.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8); index 0 = ALU, 1 = load, 2 = reduction.
- REG_W, 5, register index width.
- DATA_W, 36, scalar data width.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  request i presents a write.
- req_reg  input  NUM_REQ*REG_W  destination register; slice i = [i*REG_W +: REG_W].
- req_data  input  NUM_REQ*DATA_W  write data; slice i = [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot grant; request i accepted this cycle.
- wb_hold  input  1  block all grants this cycle (regfile busy/flush).
- wb_en  output  1  register-file write enable.
- wb_reg  output  REG_W  register-file write index.
- wb_data  output  DATA_W  register-file write data.
- wb_src  output  3  index of the requester that produced the current wb_en.
- conflict_cnt  output  CNT_W  saturating count of cycles with more than one valid request.

Behaviour:
- Reset (async, rst=1):
  - wb_en=0, wb_reg=0, wb_data=0, wb_src=0, conflict_cnt=0, rr_ptr=0.
  - req_ready=0 while rst is high.
  - A write pending when reset asserts is lost; wb_en is 0 on the first edge after reset deasserts.
- Grant (combinational within the cycle):
  - If wb_hold=1 or no req_valid is set, req_ready=0.
  - Otherwise grant the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - At most one req_ready bit is ever set; req_ready[i] never asserts without req_valid[i].
- Handshake:
  - Transfer occurs when req_valid[i] & req_ready[i].
  - The requester must hold valid, reg and data stable until transfer; dropping valid before ready is a protocol violation (assert in sim).
  - There is no combinational path from req_valid to req_ready of the same requester's next request.
- Round-robin pointer:
  - On a transfer from index g, rr_ptr <= (g+1) mod NUM_REQ; wrap from NUM_REQ-1 to 0.
  - With no transfer, rr_ptr holds.
  - Guarantees any continuously-valid requester is granted within NUM_REQ transfer cycles.
- Output stage (latency 1):
  - On a transfer in cycle N, the following are registered at edge N+1: wb_en=1, wb_reg=req_reg[g], wb_data=req_data[g], wb_src=g.
  - If cycle N has no transfer, wb_en=0 at N+1; wb_reg, wb_data and wb_src hold their previous values.
  - Back-to-back transfers produce wb_en high on consecutive cycles.
- r0 writes: accepted normally (ready asserted, rr_ptr advances), but wb_en stays 0 for that cycle; the register file is never written at index 0.
- Same destination from two requesters in one cycle: only the winner is written that cycle; the loser is written in a later cycle. Ordering between sources is the producer's responsibility.
- wb_hold=1 freezes rr_ptr and blocks grants; wb_en=0 on the next edge. Pending requests stay pending.
- conflict_cnt increments by 1 on each cycle where popcount(req_valid) >= 2, regardless of wb_hold, and saturates at all-ones.

Test Plan:
- Single request:
  - Stimulus: reset, then req_valid=3'b001, reg=r7, data=36'h0_1234_5678 for one cycle.
  - Required: req_ready=001 the same cycle; next cycle wb_en=1, wb_reg=7, wb_data=0_1234_5678, wb_src=0; the cycle after, wb_en=0.
- Round-robin fairness:
  - Stimulus: all three requesters valid continuously for 6 cycles.
  - Required: grant order 0,1,2,0,1,2; wb_src follows one cycle later; conflict_cnt=6.
- Wrap and skip:
  - Stimulus: rr_ptr=2 after granting index 1; only req 0 and req 1 valid.
  - Required: grant 0 (pointer wraps past idle index 2), then 1.
- Hold:
  - Stimulus: req 1 valid, wb_hold=1 for 3 cycles, then 0.
  - Required: req_ready=0 and wb_en=0 during hold; grant to 1 on the first cycle after hold; data written one cycle later.
- r0 discard:
  - Stimulus: req 2 writes r0 = 36'hF_FFFF_FFFF.
  - Required: req_ready[2]=1, rr_ptr advances to 0, wb_en stays 0.
- Reset mid-stream:
  - Stimulus: rst asserted asynchronously between clock edges while wb_en=1.
  - Required: wb_en, wb_reg and wb_data go to 0 immediately; rr_ptr=0; the first grant after release goes to the lowest valid index.
